// File: rtl/hc8_dma.sv
// ============================================================================
// hc8_dma : single-channel byte-copy DMA controller for the HC8 system bus.
// Optional build macro HC8_DMA_FILL_EN adds a constant-fill mode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hc8_dma #(
    parameter int GRANT_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
`ifdef HC8_DMA_FILL_EN
    input  logic        i_fill,
    input  logic [7:0]  i_fill_value,
`endif
    input  logic        i_start,
    input  logic [15:0] i_src_addr,
    input  logic [15:0] i_dst_addr,
    input  logic [15:0] i_length,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_nDMA_REQ,
    output logic [15:0] o_addr_out,
    output logic        o_addr_oe,
    input  logic [7:0]  i_data_in,
    output logic [7:0]  o_data_out,
    output logic        o_data_oe,
    output logic        o_nRAM_RD,
    output logic        o_nRAM_WR
);

    localparam int            C_WW        = $clog2(GRANT_WAIT + 1);
    localparam logic [C_WW-1:0] C_WAIT_LAST = C_WW'(GRANT_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_src;
    logic [15:0]     r_dst;
    logic [15:0]     r_rem;
    logic [7:0]      r_byte;
    logic [C_WW-1:0] r_wait;
    logic            r_abort_pend;
    logic            w_abort;
    logic            w_fill;
    logic [7:0]      w_wdata;
    logic            w_rd;
    logic            w_wr;

`ifdef HC8_DMA_FILL_EN
    logic            r_fill;
    logic [7:0]      r_fill_value;

    assign w_fill  = r_fill;
    assign w_wdata = r_fill ? r_fill_value : r_byte;
`else
    assign w_fill  = 1'b0;
    assign w_wdata = r_byte;
`endif

    // An abort seen in the current cycle counts the same as one already pending.
    assign w_abort = r_abort_pend | i_abort;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (i_length == 16'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (w_abort) begin
                    w_next = S_DONE;
                end else if (r_wait == C_WAIT_LAST) begin
                    w_next = w_fill ? S_WRITE : S_READ;
                end
            end
            S_READ:  w_next = S_WRITE;
            S_WRITE: begin
                if (r_rem == 16'd1 || w_abort) begin
                    w_next = S_DONE;
                end else begin
                    w_next = w_fill ? S_WRITE : S_READ;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_src        <= 16'h0000;
            r_dst        <= 16'h0000;
            r_rem        <= 16'h0000;
            r_byte       <= 8'h00;
            r_wait       <= '0;
            r_abort_pend <= 1'b0;
`ifdef HC8_DMA_FILL_EN
            r_fill       <= 1'b0;
            r_fill_value <= 8'h00;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                r_abort_pend <= 1'b0;
            end else begin
                r_abort_pend <= r_abort_pend | i_abort;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start && i_length != 16'd0) begin
                        r_src  <= i_src_addr;
                        r_dst  <= i_dst_addr;
                        r_rem  <= i_length;
                        r_wait <= '0;
`ifdef HC8_DMA_FILL_EN
                        r_fill       <= i_fill;
                        r_fill_value <= i_fill_value;
`endif
                    end
                end
                S_REQ:   r_wait <= r_wait + 1'b1;
                S_READ:  r_byte <= i_data_in;
                S_WRITE: begin
                    r_src <= r_src + 16'd1;
                    r_dst <= r_dst + 16'd1;
                    r_rem <= r_rem - 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign w_rd = (r_state == S_READ);
    assign w_wr = (r_state == S_WRITE);

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_nDMA_REQ = !((r_state == S_REQ) || w_rd || w_wr);
    assign o_addr_oe  = w_rd | w_wr;
    assign o_addr_out = w_rd ? r_src : (w_wr ? r_dst : 16'h0000);
    assign o_data_oe  = w_wr;
    assign o_data_out = w_wr ? w_wdata : 8'h00;
    assign o_nRAM_RD  = !w_rd;
    // Write strobe only in the clock-low half so address and data settle first.
    assign o_nRAM_WR  = !(w_wr & !clk);

endmodule

`default_nettype wire

// File: tb/tb_hc8_dma.sv
// Self-checking bench for hc8_dma: cycle-level transaction model plus RAM model.
`default_nettype none

module tb_hc8_dma;

    localparam int GW = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] src_a = '0;
    logic [15:0] dst_a = '0;
    logic [15:0] len = '0;
    logic        abort = 1'b0;
    logic        busy, done, nreq, aoe, doe, nrd, nwr;
    logic [15:0] addr_out;
    logic [7:0]  data_out;
    logic [7:0]  data_in;
`ifdef HC8_DMA_FILL_EN
    logic        fill = 1'b0;
    logic [7:0]  fill_v = 8'h00;
`endif

    hc8_dma #(.GRANT_WAIT(GW)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef HC8_DMA_FILL_EN
        .i_fill       (fill),
        .i_fill_value (fill_v),
`endif
        .i_start      (start),
        .i_src_addr   (src_a),
        .i_dst_addr   (dst_a),
        .i_length     (len),
        .i_abort      (abort),
        .o_busy       (busy),
        .o_done       (done),
        .o_nDMA_REQ   (nreq),
        .o_addr_out   (addr_out),
        .o_addr_oe    (aoe),
        .i_data_in    (data_in),
        .o_data_out   (data_out),
        .o_data_oe    (doe),
        .o_nRAM_RD    (nrd),
        .o_nRAM_WR    (nwr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy, done, nreq, aoe, doe, nrd, nwr;
        logic [15:0] addr;
        logic [7:0]  data;
    } vec_t;

    logic [7:0]  bus_mem [65536];
    logic [7:0]  ref_mem [65536];
    vec_t        exp_q [$];
    logic [15:0] rd_log [$];
    logic [15:0] wr_log [$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cnt_busy, cnt_done, cnt_nreq, cnt_rd, cnt_wr;

    always_comb data_in = bus_mem[addr_out];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    endtask

    function automatic vec_t mk(input logic b, dn, nq, ao, dO, rd, wr,
                                input logic [15:0] a, input logic [7:0] d);
        vec_t v;
        v.busy = b;  v.done = dn; v.nreq = nq; v.aoe = ao; v.doe = dO;
        v.nrd  = rd; v.nwr  = wr; v.addr = a;  v.data = d;
        return v;
    endfunction

    // Expected per-cycle outputs of one transfer, derived from the transfer rules.
    task automatic plan(input logic [15:0] s, d, input int n, input int ab,
                        input bit fl, input logic [7:0] fv, output int total);
        int per, nb, rq;
        logic [15:0] sa, da;
        logic [7:0]  b;
        if (n == 0) begin
            exp_q.push_back(mk(1, 1, 1, 0, 0, 1, 1, 16'h0, 8'h0));
            total = 1;
            return;
        end
        per = fl ? 1 : 2;
        nb  = n;
        rq  = GW;
        if (ab >= 0) begin
            if (ab < GW) begin
                rq = ab + 1;
                nb = 0;
            end else if ((ab - GW) / per + 1 < nb) begin
                nb = (ab - GW) / per + 1;
            end
        end
        repeat (rq) exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 1, 16'h0, 8'h0));
        for (int i = 0; i < nb; i++) begin
            sa = s + 16'(i);
            da = d + 16'(i);
            b  = fl ? fv : ref_mem[sa];
            ref_mem[da] = b;
            if (!fl) exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 1, sa, 8'h0));
            exp_q.push_back(mk(1, 0, 0, 1, 1, 1, 0, da, b));
        end
        exp_q.push_back(mk(1, 1, 1, 0, 0, 1, 1, 16'h0, 8'h0));
        total = rq + per * nb + 1;
    endtask

    // Per-cycle compare in the clock-low half, plus RAM write capture.
    initial begin
        vec_t e, a;
        forever begin
            @(negedge clk);
            #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(0, 0, 1, 0, 0, 1, 1, 16'h0, 8'h0);
            a = mk(busy, done, nreq, aoe, doe, nrd, nwr,
                   e.aoe ? addr_out : 16'h0, e.doe ? data_out : 8'h0);
            chk("cycle", 64'(a), 64'(e));
            cnt_busy += int'(busy);
            cnt_done += int'(done);
            cnt_nreq += int'(!nreq);
            cnt_rd   += int'(!nrd);
            cnt_wr   += int'(!nwr);
            if (!nrd && aoe) rd_log.push_back(addr_out);
            if (!nwr && doe) begin
                wr_log.push_back(addr_out);
                bus_mem[addr_out] = data_out;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("nwr_high_clk_high", 64'(nwr), 64'(1'b1));
        end
    end

    task automatic run(input logic [15:0] s, d, input int n, input int ab,
                       input bit fl, input logic [7:0] fv, input bit noise);
        int total;
        @(negedge clk);
        #2;
        cnt_busy = 0; cnt_done = 0; cnt_nreq = 0; cnt_rd = 0; cnt_wr = 0;
        rd_log.delete();
        wr_log.delete();
        src_a = s; dst_a = d; len = n[15:0]; start = 1'b1; abort = 1'b0;
`ifdef HC8_DMA_FILL_EN
        fill = fl; fill_v = fv;
`endif
        plan(s, d, n, ab, fl, fv, total);
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            #2;
            start = noise && ($urandom_range(0, 2) == 0);
            if (start) begin
                src_a = 16'($urandom);
                dst_a = 16'($urandom);
                len   = 16'($urandom_range(1, 9));
            end
            abort = (c == ab);
        end
        @(negedge clk);
        #2;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int total;
        for (int i = 0; i < 65536; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end

        // Reset, then idle with start low.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #3;
            chk("reset_vals", {busy, done, nreq, addr_out, aoe, data_out, doe, nrd, nwr},
                {1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1});
            if (c == 2) reset = 1'b0;
        end

        // Basic copy.
        bus_mem[16'h0010] = 8'hA1; bus_mem[16'h0011] = 8'hA2; bus_mem[16'h0012] = 8'hA3;
        ref_mem[16'h0010] = 8'hA1; ref_mem[16'h0011] = 8'hA2; ref_mem[16'h0012] = 8'hA3;
        run(16'h0010, 16'h0100, 3, -1, 1'b0, 8'h00, 1'b0);
        chk("copy_b0", 64'(bus_mem[16'h0100]), 64'(8'hA1));
        chk("copy_b1", 64'(bus_mem[16'h0101]), 64'(8'hA2));
        chk("copy_b2", 64'(bus_mem[16'h0102]), 64'(8'hA3));
        chk("copy_busy", 64'(cnt_busy), 64'(9));
        chk("copy_done", 64'(cnt_done), 64'(1));
        chk("copy_nreq_low", 64'(cnt_nreq), 64'(8));

        // Address wrap.
        run(16'hFFFF, 16'h7FFF, 2, -1, 1'b0, 8'h00, 1'b0);
        chk("wrap_nrd", 64'(rd_log.size()), 64'(2));
        chk("wrap_rd0", 64'(rd_log[0]), 64'(16'hFFFF));
        chk("wrap_rd1", 64'(rd_log[1]), 64'(16'h0000));
        chk("wrap_wr0", 64'(wr_log[0]), 64'(16'h7FFF));
        chk("wrap_wr1", 64'(wr_log[1]), 64'(16'h8000));

        // Zero length.
        run(16'h1234, 16'h4321, 0, -1, 1'b0, 8'h00, 1'b0);
        chk("len0_busy", 64'(cnt_busy), 64'(1));
        chk("len0_done", 64'(cnt_done), 64'(1));
        chk("len0_nreq_low", 64'(cnt_nreq), 64'(0));
        chk("len0_strobes", 64'(cnt_rd + cnt_wr), 64'(0));

        // Abort in the second READ, with ignored start noise.
        run(16'h0500, 16'h0600, 5, GW + 2, 1'b0, 8'h00, 1'b1);
        chk("abort_writes", 64'(cnt_wr), 64'(2));
        chk("abort_reads", 64'(cnt_rd), 64'(2));
        chk("abort_done", 64'(cnt_done), 64'(1));

        // Abort during REQ moves nothing.
        run(16'h0700, 16'h0800, 4, 0, 1'b0, 8'h00, 1'b0);
        chk("abort_req_busy", 64'(cnt_busy), 64'(2));
        chk("abort_req_writes", 64'(cnt_wr), 64'(0));

`ifdef HC8_DMA_FILL_EN
        run(16'h0000, 16'h0200, 4, -1, 1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 4; i++)
            chk("fill_byte", 64'(bus_mem[16'h0200 + 16'(i)]), 64'(8'h5A));
        chk("fill_no_rd", 64'(cnt_rd), 64'(0));
        chk("fill_busy", 64'(cnt_busy), 64'(7));
`endif

        // Asynchronous reset in the middle of the second WRITE.
        @(negedge clk);
        #2;
        src_a = 16'h0300; dst_a = 16'h0400; len = 16'd4; start = 1'b1;
        plan(16'h0300, 16'h0400, 4, -1, 1'b0, 8'h00, total);
        for (int c = 0; c <= GW + 3; c++) begin
            @(negedge clk);
            #2;
            start = 1'b0;
        end
        #1;
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("async_reset_release", {busy, done, nreq, aoe, doe, nrd, nwr}, 7'b0010011);
        @(negedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = bus_mem[i];

        // Randomized transfers.
        for (int t = 0; t < 40; t++) begin
            int n, ab;
            bit fl;
            n  = $urandom_range(0, 12);
            fl = 1'b0;
`ifdef HC8_DMA_FILL_EN
            fl = ($urandom_range(0, 3) == 0);
`endif
            ab = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, GW + 2 * n + 1);
            if (n == 0) ab = -1;
            run(16'($urandom), 16'($urandom), n, ab, fl, 8'($urandom), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
